seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB first, repeat_n times, with idle gaps.
// Optional even-parity bit per repetition when SEQ_GEN_PARITY_EN is defined.
module seq_gen #(
   parameter int PAT_W    = 4,
   parameter int CNT_W    = 4,
   parameter int GAP_BITS = 1
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             o,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

`ifdef SEQ_GEN_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int LEN      = PAT_W + P;
   localparam int BL_W     = $clog2(LEN);
   localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   sh_q, sh_d;
   logic [BL_W-1:0]    bl_q, bl_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [3:0]         gap_q, gap_d;
   logic               o_q, o_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept;
   logic [CNT_W-1:0]   rep_dec;
`ifdef SEQ_GEN_PARITY_EN
   logic               par_q, par_d;
`endif

   assign accept  = start && (repeat_n != '0);
   assign rep_dec = (rep_q != '0) ? rep_q - CNT_W'(1) : '0;

   // Registered outputs describe the state being entered, so every
   // transition sets o/valid/busy/done for the cycle that follows it.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sh_d    = sh_q;
      bl_d    = bl_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      o_d     = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SHIFT;
               pat_d   = pattern;
               sh_d    = {pattern[PAT_W-2:0], 1'b0};
               bl_d    = BL_W'(LEN - 1);
               rep_d   = repeat_n;
               gap_d   = '0;
               o_d     = pattern[PAT_W-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
               par_d   = ^pattern;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (bl_q != '0) begin
               bl_d    = bl_q - BL_W'(1);
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
               if (bl_q == BL_W'(1)) begin
                  o_d = par_q;
               end else begin
                  o_d  = sh_q[PAT_W-1];
                  sh_d = {sh_q[PAT_W-2:0], 1'b0};
               end
`else
               o_d  = sh_q[PAT_W-1];
               sh_d = {sh_q[PAT_W-2:0], 1'b0};
`endif
            end else begin
               rep_d = rep_dec;
               if (rep_dec == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (GAP_BITS > 0) begin
                  state_d = GAP;
                  gap_d   = 4'(GAP_LAST);
                  busy_d  = 1'b1;
               end else begin
                  sh_d    = {pat_q[PAT_W-2:0], 1'b0};
                  bl_d    = BL_W'(LEN - 1);
                  o_d     = pat_q[PAT_W-1];
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         GAP: begin
            busy_d = 1'b1;
            if (gap_q != '0) begin
               gap_d = gap_q - 4'd1;
            end else begin
               state_d = SHIFT;
               sh_d    = {pat_q[PAT_W-2:0], 1'b0};
               bl_d    = BL_W'(LEN - 1);
               o_d     = pat_q[PAT_W-1];
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         sh_q    <= '0;
         bl_q    <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         o_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sh_q    <= sh_d;
         bl_q    <= bl_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         o_q     <= o_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEQ_GEN_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign o         = o_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule
